// File: rtl/spi_sram_arbiter.sv
// Two-master arbiter sharing one spi_sram_encoder; the ack pulses the cycle after enc_busy falls.
// Requests wait while the encoder is uninitialised or busy; ARB_ROUND_ROBIN_EN selects round-robin over fixed A>B.
module spi_sram_arbiter #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 14,
  parameter int BUSY_TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [WORD_WIDTH-1:0]    a_wdata,
  output logic                     a_ack,
  output logic [WORD_WIDTH-1:0]    a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [WORD_WIDTH-1:0]    b_wdata,
  output logic                     b_ack,
  output logic [WORD_WIDTH-1:0]    b_rdata,
  input  logic                     enc_initialized,
  input  logic                     enc_busy,
  input  logic [WORD_WIDTH-1:0]    enc_rdata,
  output logic                     enc_request,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_wdata,
  output logic                     grant_b,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       grant_ok;
  logic       pick_b;
  logic       done;
  logic       abort;

  // No grant during an ack cycle, so a requester holding req high is not re-served on stale fields.
  assign grant_ok = (state == IDLE) && enc_initialized && !enc_busy &&
                    (a_req || b_req) && !(a_ack || b_ack);

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_b <= 1'b0;
    end else if (done) begin
      rr_b <= ~grant_b;
    end
  end

  assign pick_b = b_req && (!a_req || rr_b);
`else
  assign pick_b = !a_req;
`endif

  assign enc_request = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_ok) state_nxt = ISSUE;
      end
      ISSUE: begin
        cnt_nxt   = 8'd0;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (enc_busy) begin
          state_nxt = WAIT_DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
          if (cnt_nxt == 8'(BUSY_TIMEOUT)) begin
            abort     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!enc_busy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      cnt              <= 8'd0;
      grant_b          <= 1'b0;
      enc_address      <= '0;
      enc_write_enable <= 1'b0;
      enc_wdata        <= '0;
      a_ack            <= 1'b0;
      b_ack            <= 1'b0;
      a_rdata          <= '0;
      b_rdata          <= '0;
      timeout_err      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      a_ack <= done && !grant_b;
      b_ack <= done && grant_b;
      if (abort) timeout_err <= 1'b1;
      if (grant_ok) begin
        grant_b          <= pick_b;
        enc_address      <= pick_b ? b_addr  : a_addr;
        enc_write_enable <= pick_b ? b_we    : a_we;
        enc_wdata        <= pick_b ? b_wdata : a_wdata;
      end
      if (done && !enc_write_enable) begin
        if (grant_b) b_rdata <= enc_rdata;
        else         a_rdata <= enc_rdata;
      end
    end
  end

endmodule
